regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file. It is the next generation of the pipeline CPU's 2R1W register file.
- Adds configurable width, depth and read-port count.
- Adds a second write port for dual writeback (ALU + load).
- Adds write-to-read bypass on both write ports.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards.
- Sits between decode (reads, alloc) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W, entry 0 hardwired to zero
NRD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset
ra  in  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd  out  NRD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
rrdy  out  NRD  port i operand valid: register not busy, or bypassed this cycle
we0  in  1  write enable, port 0 (ALU writeback)
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (load writeback)
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
alloc_en  in  1  mark destination register busy (instruction issued)
alloc_a  in  ADDR_W  register to mark busy
busy_any  out  1  OR of all busy bits (pipeline drain indicator)

Behaviour:
- Reset: when rst=0 at a rising edge, all entries become 0 and all busy bits clear.
  - Reset overrides any same-cycle write or alloc.
  - Outputs after reset: rd = 0, rrdy = all 1, busy_any = 0.
- Reads are combinational, zero latency.
  - Address 0 returns 0 and rrdy=1, always.
  - Otherwise, if we1 && wa1==ra then rd = wd1; else if we0 && wa0==ra then rd = wd0; else rd = stored value.
- Writes commit at the rising edge. Writes to address 0 are ignored.
  - Both ports to the same non-zero address: port 1 wins, in storage and in bypass.
- Scoreboard: one busy bit per entry 1..2**ADDR_W-1. Entry 0 is never busy.
  - Next-state priority per entry:
    1. reset clears;
    2. alloc_en && alloc_a==k sets;
    3. a write to k by either port clears;
    4. otherwise hold.
  - Alloc and write to the same address in the same cycle leave the bit set: the new producer is pending.
  - alloc_a==0 is ignored.
- rrdy[i] = (ra_i==0) || !busy[ra_i] || write hit on ra_i this cycle.
  - A write hit sets rrdy regardless of the busy bit.
- busy_any reflects the registered busy bits only; same-cycle bypass does not affect it.
- Alloc to an already-busy register: stays busy; no error is flagged.
- Write to a non-busy register: legal, stores data, busy stays clear.

Optional Feature:
Macro REGFILE_MP_DBG_EN.
- Defined:
  - Adds input dbg_a [ADDR_W] and output dbg_d [DATA_W]: a combinational, non-bypassed read of stored state.
  - Adds output wr_cnt [32]: counts committed non-zero-address writes, 2 when both ports write distinct addresses, 1 on collision.
  - wr_cnt wraps modulo 2**32 and resets to 0.
- Undefined: these ports and the counter are absent. Core behaviour is identical in both cases.

Decomposition:
- Package regfile_mp_pkg holds:
  - default DATA_W/ADDR_W/NRD constants;
  - REG_ZERO address constant;
  - a write-request struct typedef {we, wa, wd}.
- One natural sub-module: regfile_mp_rdport. It holds the single-port bypass mux and rrdy logic, instantiated NRD times in a generate loop.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset values: hold rst=0 for 2 cycles after random writes -> all reads return 0, rrdy all 1, busy_any=0.
- Bypass priority: we0=1 wa0=5 wd0=0x1111 and we1=1 wa1=5 wd1=0x2222, ra0=5 in the same cycle -> rd0=0x2222 that cycle; next cycle rd0=0x2222 from storage.
- Zero register: we0=1 wa0=0 wd0=0xFFFF_FFFF, alloc_en=1 alloc_a=0 -> ra=0 gives rd=0, rrdy=1, busy_any stays 0.
- Scoreboard life cycle:
  - alloc r7 -> next cycle rrdy=0 for ra=7, busy_any=1;
  - write r7=0xABCD -> rrdy=1 and rd=0xABCD in the write cycle;
  - next cycle busy_any=0.
- Alloc/write collision: r9 busy; same cycle we0 wa0=9 and alloc r9 -> next cycle r9 still busy with data stored.
- Mid-operation reset: alloc r3, write r4=0x55, rst=0 in the next edge together with we1 wa1=3 -> all entries 0, no busy bits.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and types for the multi-port register file.
//   DATA_W_DEF / ADDR_W_DEF / NRD_DEF : default parameter values
//   REG_ZERO                           : the hardwired-zero register address
//   wr_req_t                           : one writeback request {we, wa, wd}
//                                        at the default widths
package regfile_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] wa;
    logic [DATA_W_DEF-1:0] wd;
  } wr_req_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus between decode/writeback (master) and the register
// file (slave).
//   ra/rd/rrdy         : NRD packed read ports
//   we0/wa0/wd0        : ALU writeback port
//   we1/wa1/wd1        : load writeback port
//   alloc_en/alloc_a   : mark a destination register busy
//   busy_any           : OR of all registered busy bits
//   dbg_a/dbg_d/wr_cnt : debug read and write counter, only when
//                        REGFILE_MP_DBG_EN is defined
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);

  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] rd;
  logic [NRD-1:0]        rrdy;
  logic                  we0;
  logic [ADDR_W-1:0]     wa0;
  logic [DATA_W-1:0]     wd0;
  logic                  we1;
  logic [ADDR_W-1:0]     wa1;
  logic [DATA_W-1:0]     wd1;
  logic                  alloc_en;
  logic [ADDR_W-1:0]     alloc_a;
  logic                  busy_any;

`ifdef REGFILE_MP_DBG_EN
  logic [ADDR_W-1:0]     dbg_a;
  logic [DATA_W-1:0]     dbg_d;
  logic [31:0]           wr_cnt;

  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, alloc_en, alloc_a, dbg_a,
    input  rd, rrdy, busy_any, dbg_d, wr_cnt
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, alloc_en, alloc_a, dbg_a,
    output rd, rrdy, busy_any, dbg_d, wr_cnt
  );
`else
  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, alloc_en, alloc_a,
    input  rd, rrdy, busy_any
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, alloc_en, alloc_a,
    output rd, rrdy, busy_any
  );
`endif

endinterface

// File: rtl/regfile_mp_rdport.sv
// regfile_mp_rdport: one combinational read port with write-to-read bypass.
//   ra     : read address
//   stored : registered contents of entry ra
//   busy   : registered busy bit of entry ra
//   we*/wa*/wd* : both writeback ports, for bypass and readiness
//   rd     : operand value
//   rrdy   : operand valid (zero register, not busy, or bypassed now)
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] stored,
  input  logic              busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd,
  output logic              rrdy
);

  logic is_zero;
  logic hit0;
  logic hit1;

  assign is_zero = (ra == ADDR_W'(REG_ZERO));
  assign hit0    = we0 && (wa0 == ra);
  assign hit1    = we1 && (wa1 == ra);

  // Port 1 (load) is checked first so it wins a same-address collision,
  // matching what storage will hold after the edge.
  always_comb begin
    rd = stored;
    if (is_zero)   rd = '0;
    else if (hit1) rd = wd1;
    else if (hit0) rd = wd0;
  end

  assign rrdy = is_zero || !busy || hit0 || hit1;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with dual writeback,
// write-to-read bypass and a per-register busy scoreboard.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-low reset
//   bus : regfile_mp_if.slave (read ports, two write ports, alloc, busy_any)
// Optional: define REGFILE_MP_DBG_EN to add a non-bypassed debug read
// (dbg_a/dbg_d) and a committed-write counter (wr_cnt) on the interface.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Entry 0 is reset to zero and never written, so it always reads 0.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic wr0_ok;
  logic wr1_ok;

  assign wr0_ok = bus.we0 && (bus.wa0 != ADDR_W'(REG_ZERO));
  assign wr1_ok = bus.we1 && (bus.wa1 != ADDR_W'(REG_ZERO));

  // Port 1 is written after port 0 so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (wr0_ok) mem[bus.wa0] <= bus.wd0;
      if (wr1_ok) mem[bus.wa1] <= bus.wd1;
    end
  end

  // Alloc takes priority over a same-cycle write: the newly issued
  // producer is still pending. Bit 0 stays clear forever.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if (bus.alloc_en && (bus.alloc_a == ADDR_W'(k)))
          busy[k] <= 1'b1;
        else if ((bus.we0 && (bus.wa0 == ADDR_W'(k))) ||
                 (bus.we1 && (bus.wa1 == ADDR_W'(k))))
          busy[k] <= 1'b0;
      end
    end
  end

  assign bus.busy_any = |busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    assign ra_i = bus.ra[i*ADDR_W +: ADDR_W];

    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .ra     (ra_i),
      .stored (mem[ra_i]),
      .busy   (busy[ra_i]),
      .we0    (bus.we0),
      .wa0    (bus.wa0),
      .wd0    (bus.wd0),
      .we1    (bus.we1),
      .wa1    (bus.wa1),
      .wd1    (bus.wd1),
      .rd     (bus.rd[i*DATA_W +: DATA_W]),
      .rrdy   (bus.rrdy[i])
    );
  end

`ifdef REGFILE_MP_DBG_EN
  logic [31:0] wr_cnt_q;
  logic [1:0]  wr_inc;

  // A same-address collision commits only one value, so it counts once.
  always_comb begin
    wr_inc = {1'b0, wr0_ok} + {1'b0, wr1_ok};
    if (wr0_ok && wr1_ok && (bus.wa0 == bus.wa1)) wr_inc = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) wr_cnt_q <= '0;
    else      wr_cnt_q <= wr_cnt_q + 32'(wr_inc);
  end

  assign bus.wr_cnt = wr_cnt_q;
  assign bus.dbg_d  = mem[bus.dbg_a];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp at the default
// configuration (DATA_W=32, ADDR_W=5, NRD=2). Inputs change on the falling
// edge; combinational outputs are sampled 1 time unit later, well before
// the next rising edge commits state.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam wr_req_t NO_WR = '{we: 1'b0, wa: 5'd0, wd: 32'd0};

  function automatic wr_req_t wr(input logic [4:0] a, input logic [31:0] d);
    return '{we: 1'b1, wa: a, wd: d};
  endfunction

  task automatic applyStimulus(input logic r, input wr_req_t w0, input wr_req_t w1,
                               input logic al, input logic [4:0] aa,
                               input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    rst          = r;
    bus.we0      = w0.we;
    bus.wa0      = w0.wa;
    bus.wd0      = w0.wd;
    bus.we1      = w1.we;
    bus.wa1      = w1.wa;
    bus.wd1      = w1.wd;
    bus.alloc_en = al;
    bus.alloc_a  = aa;
    bus.ra       = {r1, r0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    bus.ra = '0; bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.alloc_en = 1'b0; bus.alloc_a = '0;

    // Initialise, then dirty some state before exercising reset.
    applyStimulus(1'b0, NO_WR, NO_WR, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, wr(5'd1, 32'h1234), wr(5'd2, 32'h5678), 1'b1, 5'd6, 5'd0, 5'd0);
    applyStimulus(1'b1, wr(5'd3, 32'hDEAD), NO_WR, 1'b0, 5'd0, 5'd1, 5'd2);
    checkOutput("pre_rst_rd0", 64'(bus.rd[31:0]), 64'h1234);
    applyStimulus(1'b0, NO_WR, NO_WR, 1'b0, 5'd0, 5'd1, 5'd2);
    applyStimulus(1'b0, NO_WR, NO_WR, 1'b0, 5'd0, 5'd1, 5'd2);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd1, 5'd2);
    checkOutput("rst_rd0", 64'(bus.rd[31:0]), 64'h0);
    checkOutput("rst_rd1", 64'(bus.rd[63:32]), 64'h0);
    checkOutput("rst_rrdy", 64'(bus.rrdy), 64'h3);
    checkOutput("rst_busy_any", 64'(bus.busy_any), 64'h0);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd6, 5'd3);
    checkOutput("rst_r6_rrdy", 64'(bus.rrdy), 64'h3);
    checkOutput("rst_r3_rd1", 64'(bus.rd[63:32]), 64'h0);

    // Both ports write r5: port 1 wins in bypass and in storage.
    applyStimulus(1'b1, wr(5'd5, 32'h1111), wr(5'd5, 32'h2222), 1'b0, 5'd0, 5'd5, 5'd0);
    checkOutput("byp_prio_rd0", 64'(bus.rd[31:0]), 64'h2222);
    applyStimulus(1'b1, wr(5'd6, 32'h3333), NO_WR, 1'b0, 5'd0, 5'd5, 5'd6);
    checkOutput("stor_prio_rd0", 64'(bus.rd[31:0]), 64'h2222);
    checkOutput("byp_p0_rd1", 64'(bus.rd[63:32]), 64'h3333);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd6, 5'd5);
    checkOutput("nonbusy_wr_busy_any", 64'(bus.busy_any), 64'h0);
    checkOutput("stor_r6_rd0", 64'(bus.rd[31:0]), 64'h3333);

    // Zero register ignores writes and alloc.
    applyStimulus(1'b1, wr(5'd0, 32'hFFFF_FFFF), NO_WR, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("zero_byp_rd0", 64'(bus.rd[31:0]), 64'h0);
    checkOutput("zero_rrdy", 64'(bus.rrdy), 64'h3);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("zero_rd0", 64'(bus.rd[31:0]), 64'h0);
    checkOutput("zero_busy_any", 64'(bus.busy_any), 64'h0);

    // Scoreboard life cycle on r7.
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b1, 5'd7, 5'd7, 5'd0);
    checkOutput("alloc_cycle_rrdy", 64'(bus.rrdy), 64'h3);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("r7_busy_rrdy", 64'(bus.rrdy), 64'h2);
    checkOutput("r7_busy_any", 64'(bus.busy_any), 64'h1);
    applyStimulus(1'b1, wr(5'd7, 32'hABCD), NO_WR, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("r7_wr_rrdy", 64'(bus.rrdy), 64'h3);
    checkOutput("r7_wr_rd0", 64'(bus.rd[31:0]), 64'hABCD);
    checkOutput("r7_wr_busy_any", 64'(bus.busy_any), 64'h1);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("r7_done_busy_any", 64'(bus.busy_any), 64'h0);
    checkOutput("r7_done_rd0", 64'(bus.rd[31:0]), 64'hABCD);

    // Alloc and write to r9 in one cycle keep it busy.
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b1, 5'd9, 5'd0, 5'd9);
    applyStimulus(1'b1, wr(5'd9, 32'h9999), NO_WR, 1'b1, 5'd9, 5'd0, 5'd9);
    checkOutput("coll_byp_rrdy", 64'(bus.rrdy), 64'h3);
    checkOutput("coll_byp_rd1", 64'(bus.rd[63:32]), 64'h9999);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("coll_rrdy", 64'(bus.rrdy), 64'h1);
    checkOutput("coll_busy_any", 64'(bus.busy_any), 64'h1);
    checkOutput("coll_rd1", 64'(bus.rd[63:32]), 64'h9999);
    applyStimulus(1'b1, NO_WR, wr(5'd9, 32'h9A9A), 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("p1_clear_rrdy", 64'(bus.rrdy), 64'h3);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("p1_clear_busy_any", 64'(bus.busy_any), 64'h0);
    checkOutput("p1_clear_rd1", 64'(bus.rd[63:32]), 64'h9A9A);

    // Reset in the middle of activity overrides a same-cycle write.
    applyStimulus(1'b1, wr(5'd4, 32'h55), NO_WR, 1'b1, 5'd3, 5'd3, 5'd4);
    applyStimulus(1'b0, NO_WR, wr(5'd3, 32'h77), 1'b0, 5'd0, 5'd3, 5'd4);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd3, 5'd4);
    checkOutput("mid_rst_rd0", 64'(bus.rd[31:0]), 64'h0);
    checkOutput("mid_rst_rd1", 64'(bus.rd[63:32]), 64'h0);
    checkOutput("mid_rst_rrdy", 64'(bus.rrdy), 64'h3);
    checkOutput("mid_rst_busy_any", 64'(bus.busy_any), 64'h0);
    applyStimulus(1'b1, NO_WR, NO_WR, 1'b0, 5'd0, 5'd7, 5'd5);
    checkOutput("mid_rst_r7", 64'(bus.rd[31:0]), 64'h0);
    checkOutput("mid_rst_r5", 64'(bus.rd[63:32]), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
